// File: rtl/modmul_pm_seq.sv
// modmul_pm_seq: MSB-first digit-serial (a*b) mod (2^W - C); MODMUL_PM_FULLRED_EN adds a final canonicalising subtract.
// Latency NDIG+1 cycles from start to done; start is ignored (not queued) while busy.
module modmul_pm_seq #(
  parameter int W = 255,
  parameter int C = 19,
  parameter int D = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p_out
);

  localparam int NDIG = (W + D - 1) / D;
  localparam int RW   = NDIG * D;
  localparam int CW   = $clog2(C + 1);
  localparam int HW   = D + 1 + CW;
  localparam int CNTW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     ra_q, ra_d;
  logic [W-1:0]      rb_q, rb_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      pout_q, pout_d;

  logic [D-1:0]      dig;
  logic [W+D:0]      prod;
  logic [W+D:0]      t;
  logic [HW-1:0]     hi_c;
  logic [W:0]        t1;
  logic [W-1:0]      acc_fold;
  logic [W-1:0]      fin_val;

  // One digit step: shift-accumulate, then two folds using 2^W == C (mod p).
  always_comb begin
    dig      = ra_q[RW-1 -: D];
    prod     = (W+D+1)'(dig) * (W+D+1)'(rb_q);
    t        = {1'b0, acc_q, {D{1'b0}}} + prod;
    hi_c     = HW'(t[W+D:W]) * HW'(C);
    t1       = {1'b0, t[W-1:0]} + (W+1)'(hi_c);
    acc_fold = t1[W-1:0] + ({W{t1[W]}} & W'(C));
  end

`ifdef MODMUL_PM_FULLRED_EN
  logic [W:0] acc_plus_c;

  // acc >= p exactly when acc + C carries out of W bits; the low bits are then acc - p.
  always_comb begin
    acc_plus_c = {1'b0, acc_q} + (W+1)'(C);
    fin_val    = acc_plus_c[W] ? acc_plus_c[W-1:0] : acc_q;
  end
`else
  always_comb begin
    fin_val = acc_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pout_d  = pout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = RW'(a);
          rb_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        ra_d  = ra_q << D;
        acc_d = acc_fold;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(NDIG - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        pout_d  = fin_val;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pout_q  <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pout_q  <= pout_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign p_out = pout_q;

endmodule
